sequence_flasher: RTL and testbench



---
 rtl/simon_pkg.sv | 22 ++
 rtl/phase_timer.sv | 27 ++
 rtl/sequence_flasher.sv | 120 ++++++++++++
 tb/tb_sequence_flasher.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: FSM states, LED encodings, round limit.
package simon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StFin
    } state_t;

    localparam logic [1:0] LED_OFF   = 2'b00;
    localparam logic [1:0] LED_RIGHT = 2'b01;
    localparam logic [1:0] LED_LEFT  = 2'b10;

    localparam int unsigned MAX_ROUND = 7;

    // Bit value 1 lights the right LED, bit value 0 the left LED.
    function automatic logic [1:0] led_for_bit(input logic b);
        return b ? LED_RIGHT : LED_LEFT;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; zero flag marks the last cycle of a phase.
module phase_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load on phase change, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sequence_flasher.sv
// Plays the first (round+1) bits of the Simon pattern, LSB first, on the two LEDs.
module sequence_flasher
    import simon_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 50_000_000,
    parameter int unsigned OFF_CYCLES = 25_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] round,
    input  logic [7:0] pattern,
    output logic [1:0] led_flash,
    output logic [3:0] index,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       pattern_q;
    logic [2:0]       round_q;
    logic             last_bit;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Reload the timer whenever the FSM enters an ON or OFF phase.
    always_comb begin
        last_bit    = (index == {1'b0, round_q});
        timer_load  = 1'b0;
        timer_value = ON_LOAD;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    timer_load = 1'b1;
                end
            end
            StOn: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = OFF_LOAD;
                end
            end
            StOff: begin
                if (timer_zero && !last_bit) begin
                    timer_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencing FSM with registered LED, index, busy and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            round_q   <= '0;
            led_flash <= LED_OFF;
            index     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        pattern_q <= pattern;
                        round_q   <= round;
                        index     <= '0;
                        led_flash <= led_for_bit(pattern[0]);
                        busy      <= 1'b1;
                        state_q   <= StOn;
                    end
                end
                StOn: begin
                    if (timer_zero) begin
                        led_flash <= LED_OFF;
                        state_q   <= StOff;
                    end
                end
                StOff: begin
                    if (timer_zero) begin
                        if (last_bit) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StFin;
                        end else begin
                            // index < round_q <= 7 here, so index stays within 0..7.
                            index     <= index + 4'd1;
                            led_flash <= led_for_bit(pattern_q[index[2:0] + 3'd1]);
                            state_q   <= StOn;
                        end
                    end
                end
                StFin: begin
                    done    <= 1'b0;
                    index   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_flasher.sv
// Self-checking bench: behavioural timeline model plus directed and random stimulus.
module tb_sequence_flasher;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 2;
    localparam int unsigned BIT_C = ON_C + OFF_C;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] round;
    logic [7:0] pattern;
    logic [1:0] led_flash;
    logic [3:0] index;
    logic       busy;
    logic       done;

    sequence_flasher #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .round     (round),
        .pattern   (pattern),
        .led_flash (led_flash),
        .index     (index),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Model: cycles elapsed since the accepted start, plus the latched request.
    bit         m_active = 0;
    int         m_t      = 0;
    int         m_r      = 0;
    logic [7:0] m_p      = '0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare every output.
    task automatic step(input logic s, input logic [2:0] r, input logic [7:0] p, input logic rst);
        int len, k, ph;
        logic [1:0] e_led;
        logic [3:0] e_idx;
        logic       e_busy, e_done;
        start = s; round = r; pattern = p; reset = rst;
        @(posedge clk);
        cyc++;
        len = (m_r + 1) * BIT_C;
        if (rst) begin
            m_active = 0;
        end else if (m_active) begin
            if (m_t == len + 1) m_active = 0;
            else m_t++;
        end else if (s) begin
            m_active = 1; m_t = 1; m_r = int'(r); m_p = p;
        end
        len = (m_r + 1) * BIT_C;
        e_led = 2'b00; e_idx = 4'd0; e_busy = 1'b0; e_done = 1'b0;
        if (m_active) begin
            if (m_t <= len) begin
                k  = (m_t - 1) / BIT_C;
                ph = (m_t - 1) % BIT_C;
                e_led  = (ph < ON_C) ? (m_p[k] ? 2'b01 : 2'b10) : 2'b00;
                e_idx  = 4'(k);
                e_busy = 1'b1;
            end else begin
                e_idx  = 4'(m_r);
                e_done = 1'b1;
            end
        end
        #1;
        vectors++;
        if (led_flash !== e_led || index !== e_idx || busy !== e_busy || done !== e_done) begin
            miscompares++;
            $display("FAIL outputs cycle %0d: got led=%b idx=%0d busy=%b done=%b expected led=%b idx=%0d busy=%b done=%b",
                     cyc, led_flash, index, busy, done, e_led, e_idx, e_busy, e_done);
        end
    endtask

    // Start a playback, then run until done; returns offset of done from the start cycle.
    task automatic play(input logic [2:0] r, input logic [7:0] p, input int spur_at,
                        input logic [7:0] later_p, output int dur, output logic [1:0] first_led);
        int n;
        step(1'b1, r, p, 1'b0);
        first_led = led_flash;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            step(n == spur_at, (n == spur_at) ? 3'd3 : 3'($urandom), later_p, 1'b0);
            n++;
        end
        dur = (done === 1'b1) ? n : -1;
        step(1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    initial begin
        int dur;
        logic [1:0] fl;
        start = 0; round = 0; pattern = 0; reset = 1;
        repeat (3) step(1'b0, 3'd0, 8'h00, 1'b1);
        check("reset_led", int'(led_flash), 0);
        check("reset_busy", int'(busy), 0);
        step(1'b0, 3'd0, 8'h00, 1'b0);

        play(3'd0, 8'h01, -1, 8'h01, dur, fl);
        check("r0_done_offset", dur, 7);
        check("r0_first_led", int'(fl), 1);

        play(3'd3, 8'b0000_0110, -1, 8'h00, dur, fl);
        check("r3_done_offset", dur, 25);
        check("r3_first_led", int'(fl), 2);

        play(3'd3, 8'b0000_0110, 5, 8'h00, dur, fl);
        check("r3_spurious_start_offset", dur, 25);

        play(3'd7, 8'hA5, -1, 8'h5A, dur, fl);
        check("r7_done_offset", dur, 49);

        play(3'd7, 8'hFF, -1, 8'h00, dur, fl);
        check("ff_then_00_offset", dur, 49);
        check("ff_first_led", int'(fl), 1);

        // Reset during the third ON phase (offsets 13..16).
        step(1'b1, 3'd3, 8'h5A, 1'b0);
        repeat (13) step(1'b0, 3'd3, 8'h5A, 1'b0);
        check("third_on_index", int'(index), 2);
        step(1'b0, 3'd3, 8'h5A, 1'b1);
        check("mid_reset_led", int'(led_flash), 0);
        check("mid_reset_index", int'(index), 0);
        check("mid_reset_busy", int'(busy), 0);
        repeat (30) step(1'b0, 3'd3, 8'h5A, 1'b0);
        play(3'd1, 8'h02, -1, 8'h00, dur, fl);
        check("after_reset_offset", dur, 13);
        check("after_reset_first_led", int'(fl), 2);

        // Reset and start together: reset wins.
        step(1'b1, 3'd2, 8'hFF, 1'b1);
        check("reset_beats_start_busy", int'(busy), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 7) == 0, 3'($urandom), 8'($urandom),
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
